gnr_attractor_ctrl: RTL and testbench

Sequencing controller for the boolean gene-regulatory-network node array. For each initial state in a requested range, it loads all nodes, runs tortoise/hare stepping (s0 at half rate, s1 at full rate) until the two state copies meet, then freezes s0 and steps s1 to measure the attractor period. It emits one result record per initial state over a valid/ready handshake. It sits between the host/command logic and the node array, and is the sole driver of the nodes' shared control inputs.

---
 rtl/gnr_pkg.sv | 19 +
 rtl/gnr_attractor_ctrl_if.sv | 17 +
 rtl/gnr_result_reg.sv | 48 ++++
 rtl/gnr_attractor_ctrl.sv | 144 ++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gnr_pkg.sv
// Shared types and constants for the gene-regulatory-network attractor controller.
package gnr_pkg;

  localparam int N_NODES_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  // Below these indices s0 and s1 are trivially equal, so the meet compare is ignored.
  localparam int RUN_CMP_MIN = 2;
  localparam int PER_CMP_MIN = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PERIOD,
    REPORT
  } gnr_state_e;

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Result-record bus carrying one attractor measurement per initial state.
interface gnr_attractor_ctrl_if #(
  parameter int N_NODES = gnr_pkg::N_NODES_DEF,
  parameter int CNT_W   = gnr_pkg::CNT_W_DEF
);

  logic               valid;
  logic               ready;
  logic [N_NODES-1:0] init;
  logic [CNT_W-1:0]   steps;
  logic [CNT_W-1:0]   period;
  logic               timeout;

  modport master (output valid, init, steps, period, timeout, input ready);
  modport slave  (input valid, init, steps, period, timeout, output ready);

endinterface

// File: rtl/gnr_result_reg.sv
// Holding register for one result record; fields stay stable until the consumer accepts.
module gnr_result_reg
  import gnr_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [N_NODES-1:0] init_i,
  input  logic [CNT_W-1:0]   steps_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic               timeout_i,
  gnr_attractor_ctrl_if.master res
);

  logic               valid_q;
  logic [N_NODES-1:0] init_q;
  logic [CNT_W-1:0]   steps_q;
  logic [CNT_W-1:0]   period_q;
  logic               timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      init_q    <= '0;
      steps_q   <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      init_q    <= init_i;
      steps_q   <= steps_i;
      period_q  <= period_i;
      timeout_q <= timeout_i;
    end else if (valid_q && res.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign res.valid   = valid_q;
  assign res.init    = init_q;
  assign res.steps   = steps_q;
  assign res.period  = period_q;
  assign res.timeout = timeout_q;

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Sequences load / tortoise-hare meet / period measurement over a range of initial
// states and reports one record per state.
module gnr_attractor_ctrl
  import gnr_pkg::*;
#(
  parameter int               N_NODES   = N_NODES_DEF,
  parameter int               CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_STEPS = {CNT_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [N_NODES-1:0] init_first_i,
  input  logic [N_NODES-1:0] init_last_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               reset_nos_o,
  output logic               start_s0_o,
  output logic               start_s1_o,
  output logic [N_NODES-1:0] init_state_o,
  input  logic [N_NODES-1:0] s0_vec_i,
  input  logic [N_NODES-1:0] s1_vec_i,
  gnr_attractor_ctrl_if.master res
);

  gnr_state_e         state_q, state_d;
  logic [N_NODES-1:0] cur_init_q, last_init_q;
  logic [CNT_W-1:0]   c_q, pcnt_q, steps_q;
  logic               done_q;

  logic               match, run_hit, run_to, per_hit, per_to;
  logic               last_rec, accept;
  logic               rec_load, rec_timeout;
  logic [CNT_W-1:0]   rec_steps, rec_period;

  assign match    = (s0_vec_i == s1_vec_i);
  assign run_hit  = match && (c_q >= CNT_W'(RUN_CMP_MIN));
  assign run_to   = !run_hit && (c_q == MAX_STEPS);
  assign per_hit  = match && (pcnt_q >= CNT_W'(PER_CMP_MIN));
  assign per_to   = !per_hit && (pcnt_q == MAX_STEPS);
  assign last_rec = (cur_init_q == last_init_q);
  assign accept   = (state_q == REPORT) && res.ready;
  assign done_o   = done_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN: begin
        if (run_hit)     state_d = PERIOD;
        else if (run_to) state_d = REPORT;
      end
      PERIOD:  if (per_hit || per_to) state_d = REPORT;
      REPORT:  if (accept) state_d = last_rec ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Enables drop in the very cycle the meet is seen so both copies freeze on equal values.
  always_comb begin
    busy_o       = (state_q != IDLE);
    reset_nos_o  = 1'b0;
    start_s0_o   = 1'b0;
    start_s1_o   = 1'b0;
    init_state_o = '0;
    rec_load     = 1'b0;
    rec_steps    = c_q;
    rec_period   = '0;
    rec_timeout  = 1'b0;
    case (state_q)
      LOAD: begin
        reset_nos_o  = 1'b1;
        init_state_o = cur_init_q;
      end
      RUN: begin
        start_s0_o  = !run_hit;
        start_s1_o  = !run_hit;
        rec_load    = run_to;
        rec_timeout = 1'b1;
      end
      PERIOD: begin
        start_s1_o  = !per_hit;
        rec_load    = per_hit || per_to;
        rec_steps   = steps_q;
        rec_period  = per_hit ? pcnt_q : '0;
        rec_timeout = !per_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_init_q  <= '0;
      last_init_q <= '0;
      c_q         <= '0;
      pcnt_q      <= '0;
      steps_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= accept && last_rec;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cur_init_q  <= init_first_i;
            last_init_q <= init_last_i;
          end
        end
        LOAD: begin
          c_q    <= '0;
          pcnt_q <= '0;
        end
        RUN: begin
          c_q <= c_q + CNT_W'(1);
          if (run_hit) steps_q <= c_q;
        end
        PERIOD:  pcnt_q <= pcnt_q + CNT_W'(1);
        REPORT:  if (accept && !last_rec) cur_init_q <= cur_init_q + N_NODES'(1);
        default: ;
      endcase
    end
  end

  gnr_result_reg #(
    .N_NODES (N_NODES),
    .CNT_W   (CNT_W)
  ) u_result_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (rec_load),
    .init_i    (cur_init_q),
    .steps_i   (rec_steps),
    .period_i  (rec_period),
    .timeout_i (rec_timeout),
    .res       (res)
  );

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Self-checking bench: behavioural node array plus a trajectory-level model of the records.
module tb_gnr_attractor_ctrl;

  localparam int N    = 3;
  localparam int CW   = 16;
  localparam int MAXS = 5;

  typedef struct {
    logic [N-1:0] init;
    int           steps;
    int           period;
    logic         to;
    logic         runTo;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] initFirst = '0, initLast = '0;
  logic         busy, done, resetNos, startS0, startS1;
  logic [N-1:0] initState;
  logic [N-1:0] s0Vec = '0, s1Vec = '0;
  logic         tog = 1'b0;
  int           netMode = 0;

  int checks = 0, errors = 0;
  int accepted = 0;
  int lastSteps = 0, lastPeriod = 0, lastTimeout = 0, lastInit = 0;

  gnr_attractor_ctrl_if #(.N_NODES(N), .CNT_W(CW)) resBus ();

  gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(16'd5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .init_first_i (initFirst),
    .init_last_i  (initLast),
    .busy_o       (busy),
    .done_o       (done),
    .reset_nos_o  (resetNos),
    .start_s0_o   (startS0),
    .start_s1_o   (startS1),
    .init_state_o (initState),
    .s0_vec_i     (s0Vec),
    .s1_vec_i     (s1Vec),
    .res          (resBus)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] stepNet(input logic [N-1:0] x, input int mode);
    case (mode)
      1:       return ~x;
      2:       return x + 3'd1;
      default: return x;
    endcase
  endfunction

  // Node array: s0 moves on the 1st, 3rd, 5th... start_s0 after a load, s1 on every start_s1.
  always @(posedge clk) begin
    if (resetNos) begin
      s0Vec <= initState;
      s1Vec <= initState;
      tog   <= 1'b0;
    end else begin
      if (startS0) begin
        if (!tog) s0Vec <= stepNet(s0Vec, netMode);
        tog <= ~tog;
      end
      if (startS1) s1Vec <= stepNet(s1Vec, netMode);
    end
  end

  function automatic rec_t buildRecord(input logic [N-1:0] init, input int mode);
    logic [N-1:0] xs [0:2*MAXS+1];
    rec_t r;
    xs[0] = init;
    for (int k = 1; k <= 2*MAXS+1; k++) xs[k] = stepNet(xs[k-1], mode);
    r.init = init; r.steps = -1; r.period = 0; r.to = 1'b0; r.runTo = 1'b0;
    for (int c = 2; c <= MAXS; c++)
      if (r.steps < 0 && xs[(c+1)/2] == xs[c]) r.steps = c;
    if (r.steps < 0) begin
      r.steps = MAXS; r.to = 1'b1; r.runTo = 1'b1;
    end else begin
      r.to = 1'b1;
      for (int p = 1; p <= MAXS; p++)
        if (r.to && xs[r.steps+p] == xs[r.steps]) begin
          r.period = p; r.to = 1'b0;
        end
    end
    return r;
  endfunction

  function automatic int expLatency(input rec_t r);
    if (r.runTo) return MAXS + 2;
    return r.steps + 3 + (r.to ? MAXS : r.period);
  endfunction

  // k counts cycles since the load cycle (k = 0).
  function automatic void expEnables(input rec_t r, input int k, output logic e0, output logic e1);
    int s, pEnd;
    s = r.steps;
    pEnd = r.to ? MAXS : r.period;
    e0 = 1'b0; e1 = 1'b0;
    if (r.runTo) begin
      e0 = (k >= 1 && k <= MAXS + 1); e1 = e0;
    end else if (k >= 1 && k <= s) begin
      e0 = 1'b1; e1 = 1'b1;
    end else if (k >= s + 2 && k <= s + 2 + pEnd) begin
      e1 = r.to || (k < s + 2 + pEnd);
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  rec_t         q[$];
  logic         rstPrev = 1'b1, active = 1'b0, doneExp = 1'b0, inRec = 1'b0, prevValid = 1'b0;
  int           lat = 0;
  logic [N-1:0] snapS0 = '0, snapS1 = '0;

  always @(negedge clk) begin
    logic e0, e1, startAcc;
    if (rstPrev) begin
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstResetNos", resetNos, 0);
      checkOutput("rstStartS0", startS0, 0);
      checkOutput("rstStartS1", startS1, 0);
      checkOutput("rstInitState", initState, 0);
      checkOutput("rstValid", resBus.valid, 0);
      checkOutput("rstResInit", resBus.init, 0);
      checkOutput("rstResSteps", resBus.steps, 0);
      checkOutput("rstResPeriod", resBus.period, 0);
      checkOutput("rstResTimeout", resBus.timeout, 0);
      q.delete(); active = 1'b0; doneExp = 1'b0; inRec = 1'b0; prevValid = 1'b0;
    end else begin
      checkOutput("busy", busy, active);
      checkOutput("done", done, doneExp);
      if (resetNos) begin
        checkOutput("loadQueued", q.size() > 0, 1);
        if (q.size() > 0) checkOutput("loadInit", initState, q[0].init);
        checkOutput("loadEnables", {startS0, startS1}, 0);
        inRec = 1'b1; lat = 0;
      end else begin
        lat++;
      end
      if (resBus.valid) begin
        checkOutput("recQueued", q.size() > 0, 1);
        checkOutput("stallEnables", {startS0, startS1, resetNos}, 0);
        if (q.size() > 0) begin
          checkOutput("resInit", resBus.init, q[0].init);
          checkOutput("resPeriod", resBus.period, q[0].period);
          checkOutput("resTimeout", resBus.timeout, q[0].to);
          if (!q[0].runTo) checkOutput("resSteps", resBus.steps, q[0].steps);
          if (!prevValid) checkOutput("latency", lat, expLatency(q[0]));
        end
        if (!prevValid) begin
          snapS0 = s0Vec; snapS1 = s1Vec; inRec = 1'b0;
        end else begin
          checkOutput("stallS0", s0Vec, snapS0);
          checkOutput("stallS1", s1Vec, snapS1);
        end
      end else if (inRec && !resetNos && q.size() > 0) begin
        expEnables(q[0], lat, e0, e1);
        checkOutput("runS0", startS0, e0);
        checkOutput("runS1", startS1, e1);
      end else if (!resetNos) begin
        checkOutput("idleEnables", {startS0, startS1}, 0);
      end
      prevValid = resBus.valid;
    end
    doneExp = 1'b0;
    rstPrev = rst;
    if (!rst) begin
      startAcc = !active && start;
      if (resBus.valid && resBus.ready && q.size() > 0) begin
        lastSteps = resBus.steps; lastPeriod = resBus.period;
        lastTimeout = resBus.timeout; lastInit = resBus.init;
        void'(q.pop_front());
        accepted++;
        if (q.size() == 0) begin
          active = 1'b0; doneExp = 1'b1;
        end
      end
      if (startAcc) begin
        logic [N-1:0] v;
        v = initFirst;
        active = 1'b1;
        for (int i = 0; i < (1 << N); i++) begin
          q.push_back(buildRecord(v, netMode));
          if (v == initLast) break;
          v = v + 3'd1;
        end
      end
    end
  end

  task automatic pulseStart(input logic [N-1:0] first, input logic [N-1:0] last);
    initFirst = first; initLast = last; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [N-1:0] first, input logic [N-1:0] last, input int mode);
    netMode = mode;
    pulseStart(first, last);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (!done) checkOutput("doneWait", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic waitValid(input int limit);
    int n = 0;
    while (!resBus.valid && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (!resBus.valid) checkOutput("validWait", 0, 1);
  endtask

  initial begin
    rec_t r;
    int base;
    resBus.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    r = buildRecord(3'b101, 0);
    checkOutput("modelIdSteps", r.steps, 2);
    checkOutput("modelIdPeriod", r.period, 1);
    r = buildRecord(3'b000, 1);
    checkOutput("modelInvSteps", r.steps, 4);
    checkOutput("modelInvPeriod", r.period, 2);
    r = buildRecord(3'b000, 2);
    checkOutput("modelCntTimeout", r.to, 1);
    checkOutput("modelCntPeriod", r.period, 0);

    base = accepted;
    applyStimulus(3'b101, 3'b101, 0);
    waitDone(200);
    checkOutput("idRecords", accepted - base, 1);
    checkOutput("idSteps", lastSteps, 2);
    checkOutput("idPeriod", lastPeriod, 1);
    checkOutput("idTimeout", lastTimeout, 0);

    base = accepted;
    applyStimulus(3'b000, 3'b000, 1);
    waitDone(200);
    checkOutput("invSteps", lastSteps, 4);
    checkOutput("invPeriod", lastPeriod, 2);

    base = accepted;
    applyStimulus(3'b110, 3'b001, 1);
    repeat (3) @(posedge clk);
    #1 pulseStart(3'b101, 3'b101);
    waitDone(400);
    checkOutput("sweepRecords", accepted - base, 4);
    checkOutput("sweepLastInit", lastInit, 1);
    checkOutput("sweepPeriod", lastPeriod, 2);

    base = accepted;
    resBus.ready = 1'b0;
    applyStimulus(3'b000, 3'b000, 1);
    waitValid(200);
    repeat (10) @(posedge clk);
    #1 resBus.ready = 1'b1;
    waitDone(200);
    checkOutput("stallRecords", accepted - base, 1);

    applyStimulus(3'b000, 3'b000, 2);
    waitDone(200);
    checkOutput("cntTimeout", lastTimeout, 1);
    checkOutput("cntPeriod", lastPeriod, 0);

    base = accepted;
    applyStimulus(3'b000, 3'b000, 1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortRecords", accepted - base, 0);
    applyStimulus(3'b000, 3'b000, 1);
    waitDone(200);
    checkOutput("rerunRecords", accepted - base, 1);
    checkOutput("rerunSteps", lastSteps, 4);
    checkOutput("rerunPeriod", lastPeriod, 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
